// File: rtl/fb_port_arbiter_if.sv
// Port bundle of the frame-buffer arbiter: display read path, processing engine, BRAM primitive.
// proc_req/proc_gnt: the engine holds req/we/addr/wdata stable until proc_gnt is seen high in a cycle.
interface fb_port_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12
);
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_flush;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;
    logic              proc_req;
    logic              proc_we;
    logic [ADDR_W-1:0] proc_addr;
    logic [DATA_W-1:0] proc_wdata;
    logic              proc_gnt;
    logic              proc_rvalid;
    logic [DATA_W-1:0] proc_rdata;
    logic              proc_starve;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  disp_req, disp_addr, disp_flush, proc_req, proc_we, proc_addr, proc_wdata, mem_rdata,
        output disp_rvalid, disp_rdata, proc_gnt, proc_rvalid, proc_rdata, proc_starve,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output disp_req, disp_addr, disp_flush, proc_req, proc_we, proc_addr, proc_wdata, mem_rdata,
        input  disp_rvalid, disp_rdata, proc_gnt, proc_rvalid, proc_rdata, proc_starve,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: display reads win, repeated display addresses are served
// from a held register, and every read returns exactly 1+RD_LAT cycles after acceptance.
module fb_port_arbiter #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 12,
    parameter int DEPTH        = 120000,
    parameter int RD_LAT       = 2,
    parameter int STARVE_LIMIT = 1023
) (
    input logic              clk,
    input logic              rst,
    fb_port_arbiter_if.slave bus
);
    typedef enum logic [2:0] {
        TAG_NONE, TAG_DISP_MEM, TAG_DISP_HIT, TAG_DISP_OOR, TAG_PROC_MEM, TAG_PROC_OOR
    } tag_e;

    localparam int                PIPE_D   = 1 + RD_LAT;
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [9:0]        STARVE_A = 10'(STARVE_LIMIT);

    logic              last_vld_q, last_vld_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    tag_e              disp_tag_q [PIPE_D];
    tag_e              proc_tag_q [PIPE_D];
    tag_e              disp_tag_d, proc_tag_d;
    logic [DATA_W-1:0] disp_hold_q, disp_hold_d;
    logic [DATA_W-1:0] proc_hold_q, proc_hold_d;
    logic [9:0]        wait_q, wait_d;

    logic hit, disp_miss, proc_gnt, disp_in_range, proc_in_range;

    always_comb begin
        disp_in_range = bus.disp_addr < DEPTH_A;
        proc_in_range = bus.proc_addr < DEPTH_A;
        hit           = bus.disp_req & last_vld_q & (bus.disp_addr == last_addr_q) & ~bus.disp_flush;
        disp_miss     = bus.disp_req & ~hit;
        proc_gnt      = bus.proc_req & ~disp_miss;
    end

    // Acceptance: dedup history update, registered memory command and the return tag for each lane.
    always_comb begin
        last_vld_d  = last_vld_q;
        last_addr_d = last_addr_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        disp_tag_d  = TAG_NONE;
        proc_tag_d  = TAG_NONE;
        if (bus.disp_flush) last_vld_d = 1'b0;
        if (disp_miss) begin
            last_vld_d  = 1'b1;
            last_addr_d = bus.disp_addr;
            mem_en_d    = disp_in_range;
            mem_addr_d  = bus.disp_addr;
            disp_tag_d  = disp_in_range ? TAG_DISP_MEM : TAG_DISP_OOR;
        end else begin
            if (hit) disp_tag_d = TAG_DISP_HIT;
            if (proc_gnt) begin
                mem_en_d    = proc_in_range;
                mem_we_d    = bus.proc_we & proc_in_range;
                mem_addr_d  = bus.proc_addr;
                mem_wdata_d = bus.proc_wdata;
                if (bus.proc_we) begin
                    // A write under the held display word makes the held copy stale.
                    if (bus.proc_addr == last_addr_q) last_vld_d = 1'b0;
                end else begin
                    proc_tag_d = proc_in_range ? TAG_PROC_MEM : TAG_PROC_OOR;
                end
            end
        end
    end

    // The last tag stage lines up with mem_rdata, so returns are steered straight from the BRAM.
    always_comb begin
        disp_hold_d = disp_hold_q;
        proc_hold_d = proc_hold_q;
        case (disp_tag_q[RD_LAT])
            TAG_DISP_MEM: disp_hold_d = bus.mem_rdata;
            TAG_DISP_OOR: disp_hold_d = '0;
            default:      ;
        endcase
        case (proc_tag_q[RD_LAT])
            TAG_PROC_MEM: proc_hold_d = bus.mem_rdata;
            TAG_PROC_OOR: proc_hold_d = '0;
            default:      ;
        endcase
        if (bus.proc_req & ~proc_gnt) wait_d = (wait_q == 10'h3FF) ? wait_q : wait_q + 10'd1;
        else                          wait_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_vld_q  <= 1'b0;
            last_addr_q <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            disp_hold_q <= '0;
            proc_hold_q <= '0;
            wait_q      <= '0;
            for (int i = 0; i < PIPE_D; i++) begin
                disp_tag_q[i] <= TAG_NONE;
                proc_tag_q[i] <= TAG_NONE;
            end
        end else begin
            last_vld_q    <= last_vld_d;
            last_addr_q   <= last_addr_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            disp_hold_q   <= disp_hold_d;
            proc_hold_q   <= proc_hold_d;
            wait_q        <= wait_d;
            disp_tag_q[0] <= disp_tag_d;
            proc_tag_q[0] <= proc_tag_d;
            for (int i = 1; i < PIPE_D; i++) begin
                disp_tag_q[i] <= disp_tag_q[i-1];
                proc_tag_q[i] <= proc_tag_q[i-1];
            end
        end
    end

    assign bus.proc_gnt    = proc_gnt;
    assign bus.proc_starve = wait_q >= STARVE_A;
    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.disp_rvalid = (disp_tag_q[RD_LAT] == TAG_DISP_MEM) || (disp_tag_q[RD_LAT] == TAG_DISP_HIT) ||
                             (disp_tag_q[RD_LAT] == TAG_DISP_OOR);
    assign bus.disp_rdata  = disp_hold_d;
    assign bus.proc_rvalid = (proc_tag_q[RD_LAT] == TAG_PROC_MEM) || (proc_tag_q[RD_LAT] == TAG_PROC_OOR);
    assign bus.proc_rdata  = proc_hold_d;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: BRAM model with word = address, a transaction-level reference model
// checked every cycle, and directed scenarios with hand-computed expectations.
module tb_fb_port_arbiter;
    localparam int AW = 17, DW = 12, DEPTH = 120000, RD_LAT = 2, STARVE_LIMIT = 1023;

    // ---- clock / reset ----
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fb_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    fb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT),
                      .STARVE_LIMIT(STARVE_LIMIT)) dut (.clk(clk), .rst(rst), .bus(bus));

    // ---- BRAM model ----
    logic [DW-1:0] bram    [DEPTH];
    logic [DW-1:0] rd_pipe [RD_LAT];
    assign bus.mem_rdata = rd_pipe[RD_LAT-1];
    always @(posedge clk) begin
        if (bus.mem_en && int'(bus.mem_addr) < DEPTH) begin
            if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_wdata;
            else            rd_pipe[0] <= bram[bus.mem_addr];
        end
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end

    // ---- scoreboard ----
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    logic [DW-1:0] mdl_mem [DEPTH];
    logic [DW-1:0] exp_disp_q[$];
    logic [DW-1:0] exp_proc_q[$];
    int            due_disp_q[$];
    int            due_proc_q[$];
    logic          m_vld = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_disp_data = '0;
    logic [DW-1:0] m_proc_data = '0;
    int            m_wait = 0;
    logic          iss_en = 1'b0, iss_we = 1'b0;
    logic [AW-1:0] iss_addr = '0;
    logic [DW-1:0] iss_wdata = '0;
    logic          exp_dv, exp_pv, m_hit, m_miss, m_gnt, d_rng, p_rng;

    // Reference model: compare this cycle's outputs, then apply this cycle's accepted requests.
    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            exp_dv = 1'b0;
            exp_pv = 1'b0;
            if (due_disp_q.size() > 0) if (due_disp_q[0] == cyc) begin
                exp_dv = 1'b1;
                m_disp_data = exp_disp_q.pop_front();
                void'(due_disp_q.pop_front());
            end
            if (due_proc_q.size() > 0) if (due_proc_q[0] == cyc) begin
                exp_pv = 1'b1;
                m_proc_data = exp_proc_q.pop_front();
                void'(due_proc_q.pop_front());
            end
            d_rng  = int'(bus.disp_addr) < DEPTH;
            p_rng  = int'(bus.proc_addr) < DEPTH;
            m_hit  = bus.disp_req && m_vld && bus.disp_addr == m_addr && !bus.disp_flush;
            m_miss = bus.disp_req && !m_hit;
            m_gnt  = bus.proc_req && !m_miss;
            chk("mdl_disp_rvalid", bus.disp_rvalid, exp_dv);
            chk("mdl_disp_rdata", bus.disp_rdata, m_disp_data);
            chk("mdl_proc_rvalid", bus.proc_rvalid, exp_pv);
            if (exp_pv) chk("mdl_proc_rdata", bus.proc_rdata, m_proc_data);
            chk("mdl_mem_en", bus.mem_en, iss_en);
            if (iss_en) begin
                chk("mdl_mem_we", bus.mem_we, iss_we);
                chk("mdl_mem_addr", bus.mem_addr, iss_addr);
                if (iss_we) chk("mdl_mem_wdata", bus.mem_wdata, iss_wdata);
            end
            chk("mdl_proc_gnt", bus.proc_gnt, m_gnt);
            chk("mdl_proc_starve", bus.proc_starve, m_wait >= STARVE_LIMIT);
            if (rst) begin
                exp_disp_q.delete(); due_disp_q.delete();
                exp_proc_q.delete(); due_proc_q.delete();
                m_vld = 1'b0; m_wait = 0; m_disp_data = '0; iss_en = 1'b0;
            end else begin
                iss_en = 1'b0;
                iss_we = 1'b0;
                if (bus.disp_flush) m_vld = 1'b0;
                if (m_miss) begin
                    m_vld  = 1'b1;
                    m_addr = bus.disp_addr;
                    exp_disp_q.push_back(d_rng ? mdl_mem[bus.disp_addr] : '0);
                    due_disp_q.push_back(cyc + 1 + RD_LAT);
                    if (d_rng) begin iss_en = 1'b1; iss_addr = bus.disp_addr; end
                end else if (m_hit) begin
                    exp_disp_q.push_back(d_rng ? mdl_mem[bus.disp_addr] : '0);
                    due_disp_q.push_back(cyc + 1 + RD_LAT);
                end
                if (m_gnt) begin
                    if (bus.proc_we) begin
                        if (p_rng) begin
                            mdl_mem[bus.proc_addr] = bus.proc_wdata;
                            iss_en = 1'b1; iss_we = 1'b1;
                            iss_addr = bus.proc_addr; iss_wdata = bus.proc_wdata;
                        end
                        if (bus.proc_addr == m_addr) m_vld = 1'b0;
                    end else begin
                        exp_proc_q.push_back(p_rng ? mdl_mem[bus.proc_addr] : '0);
                        due_proc_q.push_back(cyc + 1 + RD_LAT);
                        if (p_rng) begin iss_en = 1'b1; iss_addr = bus.proc_addr; end
                    end
                end
                if (bus.proc_req && !m_gnt) m_wait = (m_wait >= 1023) ? 1023 : m_wait + 1;
                else                        m_wait = 0;
            end
        end
    end

    // ---- driver tasks ----
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.disp_req = 1'b0; bus.disp_addr = '0; bus.disp_flush = 1'b0;
        bus.proc_req = 1'b0; bus.proc_we = 1'b0; bus.proc_addr = '0; bus.proc_wdata = '0;
    endtask

    task automatic disp(input int a);
        bus.disp_req = 1'b1;
        bus.disp_addr = AW'(a);
    endtask

    task automatic proc(input logic we, input int a, input int d);
        bus.proc_req = 1'b1; bus.proc_we = we; bus.proc_addr = AW'(a); bus.proc_wdata = DW'(d);
    endtask

    // ---- directed stimulus ----
    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            bram[i] = DW'(i);
            mdl_mem[i] = DW'(i);
        end
        for (int k = 0; k < RD_LAT; k++) rd_pipe[k] = '0;
        idle();
        rst = 1'b1;
        step();
        chk_en = 1'b1;
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_disp_rvalid", bus.disp_rvalid, 0);
        chk("rst_disp_rdata", bus.disp_rdata, 0);
        chk("rst_proc_rvalid", bus.proc_rvalid, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_proc_starve", bus.proc_starve, 0);

        // three display misses 5, 6, 5
        step(); disp(5);
        step(); disp(6);
        step(); disp(5);
        step(); idle();
        @(negedge clk); chk("t1_rv0", bus.disp_rvalid, 1); chk("t1_d0", bus.disp_rdata, 5);
        step(); @(negedge clk); chk("t1_rv1", bus.disp_rvalid, 1); chk("t1_d1", bus.disp_rdata, 6);
        step(); @(negedge clk); chk("t1_rv2", bus.disp_rvalid, 1); chk("t1_d2", bus.disp_rdata, 5);

        // display 10 twice with a processing read of 20 held
        step(); bus.disp_flush = 1'b1;
        step(); idle(); disp(10); proc(1'b0, 20, 0);
        @(negedge clk); chk("t2_gnt_c0", bus.proc_gnt, 0);
        step(); disp(10);
        @(negedge clk); chk("t2_gnt_c1", bus.proc_gnt, 1); chk("t2_mem_a0", bus.mem_addr, 10);
        step(); idle();
        @(negedge clk); chk("t2_mem_a1", bus.mem_addr, 20); chk("t2_mem_en1", bus.mem_en, 1);
        step(); @(negedge clk); chk("t2_disp_d0", bus.disp_rdata, 10);
        step(); @(negedge clk);
        chk("t2_disp_rv1", bus.disp_rvalid, 1); chk("t2_disp_d1", bus.disp_rdata, 10);
        chk("t2_proc_rv", bus.proc_rvalid, 1); chk("t2_proc_d", bus.proc_rdata, 20);

        // processing write of 0xABC to 10 between display reads of 10
        step(); proc(1'b1, 10, 'hABC);
        @(negedge clk); chk("t3_wgnt", bus.proc_gnt, 1);
        step(); idle(); disp(10);
        @(negedge clk); chk("t3_mem_we", bus.mem_we, 1); chk("t3_mem_wd", bus.mem_wdata, 'hABC);
        step(); idle();
        @(negedge clk); chk("t3_reread_en", bus.mem_en, 1); chk("t3_reread_we", bus.mem_we, 0);
        step(); step(); @(negedge clk);
        chk("t3_rv", bus.disp_rvalid, 1); chk("t3_d", bus.disp_rdata, 'hABC);

        // out-of-range processing read and write
        step(); proc(1'b0, 120000, 0);
        @(negedge clk); chk("t4_rgnt", bus.proc_gnt, 1);
        step(); proc(1'b1, 130000, 'h123);
        @(negedge clk); chk("t4_wgnt", bus.proc_gnt, 1); chk("t4_en_r", bus.mem_en, 0);
        step(); idle();
        @(negedge clk); chk("t4_en_w", bus.mem_en, 0);
        step(); @(negedge clk); chk("t4_rv", bus.proc_rvalid, 1); chk("t4_d", bus.proc_rdata, 0);

        // flush concurrent with a repeat address is a miss; a later repeat is a hit
        step(); disp(40);
        step(); disp(40); bus.disp_flush = 1'b1;
        step(); idle(); disp(40);
        @(negedge clk); chk("t7_flush_miss", bus.mem_en, 1); chk("t7_flush_addr", bus.mem_addr, 40);
        step(); idle();
        @(negedge clk); chk("t7_hit_noen", bus.mem_en, 0);
        repeat (4) step();

        // continuous distinct display misses starve the engine
        proc(1'b0, 7, 0);
        for (int i = 0; i < 1030; i++) begin
            disp(2000 + i);
            @(negedge clk);
            if (i == 1022) chk("t5_starve_lo", bus.proc_starve, 0);
            if (i == 1023) chk("t5_starve_hi", bus.proc_starve, 1);
            step();
        end
        bus.disp_req = 1'b0;
        @(negedge clk); chk("t5_gnt", bus.proc_gnt, 1); chk("t5_starve_held", bus.proc_starve, 1);
        step(); idle();
        @(negedge clk); chk("t5_starve_clr", bus.proc_starve, 0);
        repeat (6) step();

        // reset with two reads in flight
        disp(30);
        step(); disp(31);
        step(); idle(); rst = 1'b1;
        step(); rst = 1'b0;
        @(negedge clk);
        chk("t6_disp_rdata", bus.disp_rdata, 0);
        chk("t6_mem_en", bus.mem_en, 0);
        chk("t6_mem_addr", bus.mem_addr, 0);
        chk("t6_proc_gnt", bus.proc_gnt, 0);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin step(); @(negedge clk); end
            chk("t6_no_disp_rv", bus.disp_rvalid, 0);
            chk("t6_no_proc_rv", bus.proc_rvalid, 0);
        end

        // recovery read after reset
        step(); disp(9);
        step(); idle();
        step(); step(); @(negedge clk);
        chk("t8_rv", bus.disp_rvalid, 1); chk("t8_d", bus.disp_rdata, 9);
        repeat (6) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
